// File: rtl/tlu_trigger_fifo.sv
// tlu_trigger_fifo: snapshots time stamp/trigger ID per accepted trigger, serialises a 3-word record into a FWFT FIFO, counts dropped triggers
module tlu_trigger_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  CLK40,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  TRIG,
  input  logic [63:0]           TIME_STAMP,
  input  logic [31:0]           TRIG_ID,
  input  logic                  FIFO_READ,
  output logic                  FIFO_EMPTY,
  output logic [31:0]           FIFO_DATA,
  output logic [DEPTH_LOG2:0]   FIFO_WORDS,
  output logic [7:0]            LOST_DATA_CNT,
  output logic                  BUSY
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, WR0, WR1, WR2} state_t;
  state_t state_q, state_d;
  logic [53:0] ts_q;
  logic [29:0] id_q;
  logic [5:0] lost_snap_q;
  logic [31:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic [7:0] lost_q, lost_d;
  logic [DEPTH_LOG2+1:0] free;
  logic accept, start, drop, wr, pop;
  logic [31:0] wdata;
  logic unused_bits;
  assign unused_bits = ^{TIME_STAMP[63:54], TRIG_ID[31:30]};
  always_comb begin
    free = (DEPTH_LOG2 + 2)'(DEPTH) - {1'b0, cnt_q};
    accept = free >= (DEPTH_LOG2 + 2)'(3);
    start = state_q == IDLE && TRIG && EN && accept;
    drop = TRIG && EN && !start;
    wr = state_q != IDLE;
    pop = FIFO_READ && cnt_q != '0;
    cnt_d = cnt_q + (DEPTH_LOG2 + 1)'(wr) - (DEPTH_LOG2 + 1)'(pop);
    lost_d = drop && lost_q != 8'hFF ? lost_q + 8'd1 : lost_q;
    state_d = state_q == IDLE ? (start ? WR0 : IDLE) : state_q == WR2 ? IDLE : state_t'(state_q + 2'd1);
    wdata = state_q == WR0 ? {2'b10, id_q} : state_q == WR1 ? {2'b01, ts_q[29:0]} : {2'b00, lost_snap_q, ts_q[53:30]};
  end
  always_ff @(posedge CLK40)
    if (RST) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      lost_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lost_q <= lost_d;
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  // Snapshot and RAM need no reset: they are only observed through reset-cleared state
  always_ff @(posedge CLK40) begin
    if (start) begin
      ts_q <= TIME_STAMP[53:0];
      id_q <= TRIG_ID[29:0];
      lost_snap_q <= lost_q > 8'd63 ? 6'h3F : lost_q[5:0];
    end
    if (wr) mem_q[wptr_q] <= wdata;
  end
  assign FIFO_EMPTY = cnt_q == '0;
  assign FIFO_DATA = FIFO_EMPTY ? 32'd0 : mem_q[rptr_q];
  assign FIFO_WORDS = cnt_q;
  assign LOST_DATA_CNT = lost_q;
  assign BUSY = state_q != IDLE;
endmodule

// File: tb/tb_tlu_trigger_fifo.sv
// tb_tlu_trigger_fifo: randomized and directed checks of tlu_trigger_fifo against a queue-based record model
module tb_tlu_trigger_fifo;
  logic CLK40 = 0, RST = 1, EN = 0, TRIG = 0, FIFO_READ = 0;
  logic [63:0] TIME_STAMP = '0;
  logic [31:0] TRIG_ID = '0;
  logic FIFO_EMPTY, BUSY;
  logic [31:0] FIFO_DATA;
  logic [9:0] FIFO_WORDS;
  logic [7:0] LOST_DATA_CNT;
  logic s_rst = 1, s_trig = 0, s_read = 0, s_empty, s_busy;
  logic [31:0] s_data;
  logic [2:0] s_words;
  logic [7:0] s_lost;
  logic [31:0] exp_q[$], pend[$];
  int lost, n, nf;
  always #5 CLK40 = ~CLK40;
  tlu_trigger_fifo u_dut (.CLK40(CLK40), .RST(RST), .EN(EN), .TRIG(TRIG), .TIME_STAMP(TIME_STAMP),
    .TRIG_ID(TRIG_ID), .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
    .FIFO_WORDS(FIFO_WORDS), .LOST_DATA_CNT(LOST_DATA_CNT), .BUSY(BUSY));
  tlu_trigger_fifo #(.DEPTH_LOG2(2)) u_small (.CLK40(CLK40), .RST(s_rst), .EN(1'b1), .TRIG(s_trig),
    .TIME_STAMP(TIME_STAMP), .TRIG_ID(TRIG_ID), .FIFO_READ(s_read), .FIFO_EMPTY(s_empty),
    .FIFO_DATA(s_data), .FIFO_WORDS(s_words), .LOST_DATA_CNT(s_lost), .BUSY(s_busy));
  // One clock of the 512-word DUT; the model works on whole records and the FIFO as a queue
  task automatic step(input logic t, e, r, rs, input logic [63:0] ts, input logic [31:0] id);
    bit idle;
    int sz, l6;
    TRIG = t; EN = e; FIFO_READ = r; RST = rs; TIME_STAMP = ts; TRIG_ID = id;
    @(posedge CLK40);
    if (rs) begin
      exp_q.delete(); pend.delete(); lost = 0;
    end else begin
      sz = exp_q.size();
      idle = pend.size() == 0;
      if (r && sz > 0) void'(exp_q.pop_front());
      if (!idle) exp_q.push_back(pend.pop_front());
      if (t && e) begin
        if (idle && 512 - sz >= 3) begin
          l6 = lost > 63 ? 63 : lost;
          pend.push_back({2'b10, id[29:0]});
          pend.push_back({2'b01, ts[29:0]});
          pend.push_back({2'b00, 6'(l6), ts[53:30]});
        end else if (lost < 255) lost++;
      end
    end
    @(negedge CLK40);
  endtask
  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) step(0, 1, 0, 0, '0, '0);
  endtask
  task automatic drain(input string name);
    int k;
    k = exp_q.size();
    for (int i = 0; i < k; i++) begin
      n++;
      if (FIFO_DATA !== exp_q[0]) begin nf++; $display("FAIL %s word %0d: got %h exp %h", name, i, FIFO_DATA, exp_q[0]); end
      step(0, 1, 1, 0, '0, '0);
    end
    n++;
    if (FIFO_EMPTY !== 1'b1) begin nf++; $display("FAIL %s empty after drain: got %b exp 1", name, FIFO_EMPTY); end
  endtask
  task automatic test_reset;
    step(0, 0, 0, 1, '0, '0);
    n++;
    if ({FIFO_EMPTY, FIFO_DATA, FIFO_WORDS, LOST_DATA_CNT, BUSY} !== {1'b1, 32'd0, 10'd0, 8'd0, 1'b0}) begin
      nf++; $display("FAIL reset: empty %b data %h words %0d lost %0d busy %b exp 1/0/0/0/0", FIFO_EMPTY, FIFO_DATA, FIFO_WORDS, LOST_DATA_CNT, BUSY);
    end
  endtask
  task automatic test_single;
    step(1, 1, 0, 0, 64'h0000_0000_4000_0005, 32'h0000_0007);
    n++;
    if (BUSY !== 1'b1 || FIFO_EMPTY !== 1'b1) begin nf++; $display("FAIL single_k: busy %b empty %b exp 1 1", BUSY, FIFO_EMPTY); end
    idle_cycles(1);
    n++;
    if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== 32'h8000_0007) begin nf++; $display("FAIL single_k1: empty %b data %h exp 0 80000007", FIFO_EMPTY, FIFO_DATA); end
    idle_cycles(2);
    n++;
    if (FIFO_WORDS !== 10'd3 || BUSY !== 1'b0) begin nf++; $display("FAIL single_k3: words %0d busy %b exp 3 0", FIFO_WORDS, BUSY); end
    step(0, 1, 1, 0, '0, '0);
    n++;
    if (FIFO_DATA !== 32'h4000_0005) begin nf++; $display("FAIL single_w1: got %h exp 40000005", FIFO_DATA); end
    step(0, 1, 1, 0, '0, '0);
    n++;
    if (FIFO_DATA !== 32'h0000_0001) begin nf++; $display("FAIL single_w2: got %h exp 00000001", FIFO_DATA); end
    drain("single");
  endtask
  task automatic test_read_empty;
    step(0, 1, 1, 0, '0, '0);
    n++;
    if ({FIFO_EMPTY, FIFO_DATA, FIFO_WORDS, LOST_DATA_CNT, BUSY} !== {1'b1, 32'd0, 10'd0, 8'd0, 1'b0}) begin
      nf++; $display("FAIL read_empty: empty %b data %h words %0d lost %0d busy %b", FIFO_EMPTY, FIFO_DATA, FIFO_WORDS, LOST_DATA_CNT, BUSY);
    end
  endtask
  task automatic test_back_to_back;
    step(0, 0, 0, 1, '0, '0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, {$urandom, $urandom}, $urandom);
    idle_cycles(3);
    n++;
    if (LOST_DATA_CNT !== 8'd4 || FIFO_WORDS !== 10'd6) begin nf++; $display("FAIL b2b: lost %0d words %0d exp 4 6", LOST_DATA_CNT, FIFO_WORDS); end
    n++;
    if (exp_q.size() == 6 && FIFO_DATA[31:30] !== 2'b10) begin nf++; $display("FAIL b2b_start: got %b exp 10", FIFO_DATA[31:30]); end
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, '0, '0);
    n++;
    if (FIFO_DATA[29:24] !== 6'd3) begin nf++; $display("FAIL b2b_lostfield: got %0d exp 3", FIFO_DATA[29:24]); end
    drain("b2b");
  endtask
  task automatic test_concurrent;
    logic [63:0] ts;
    ts = {$urandom, $urandom};
    step(0, 0, 0, 1, '0, '0);
    step(1, 1, 0, 0, ts, $urandom);
    idle_cycles(1);
    n++;
    if (FIFO_WORDS !== 10'd1) begin nf++; $display("FAIL conc_pre: words %0d exp 1", FIFO_WORDS); end
    step(0, 1, 1, 0, '0, '0);
    n++;
    if (FIFO_WORDS !== 10'd1 || FIFO_DATA !== {2'b01, ts[29:0]}) begin nf++; $display("FAIL conc_pop: words %0d data %h exp 1 %h", FIFO_WORDS, FIFO_DATA, {2'b01, ts[29:0]}); end
    idle_cycles(1);
    n++;
    if (FIFO_WORDS !== 10'd2) begin nf++; $display("FAIL conc_post: words %0d exp 2", FIFO_WORDS); end
    drain("conc");
  endtask
  task automatic test_saturation;
    step(0, 0, 0, 1, '0, '0);
    for (int i = 0; i < 400; i++) step(1, 1, 0, 0, {$urandom, $urandom}, $urandom);
    idle_cycles(3);
    n++;
    if (LOST_DATA_CNT !== 8'hFF || FIFO_WORDS !== 10'd300) begin nf++; $display("FAIL sat: lost %h words %0d exp ff 300", LOST_DATA_CNT, FIFO_WORDS); end
    step(1, 1, 0, 0, {$urandom, $urandom}, $urandom);
    idle_cycles(3);
    for (int i = 0; i < 302; i++) step(0, 1, 1, 0, '0, '0);
    n++;
    if (FIFO_DATA[29:24] !== 6'h3F) begin nf++; $display("FAIL sat_lostfield: got %h exp 3f", FIFO_DATA[29:24]); end
    drain("sat");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, {$urandom, $urandom}, $urandom);
    n++;
    if (FIFO_WORDS !== 10'd0 || LOST_DATA_CNT !== 8'hFF || BUSY !== 1'b0) begin nf++; $display("FAIL en_low: words %0d lost %h busy %b exp 0 ff 0", FIFO_WORDS, LOST_DATA_CNT, BUSY); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] id;
    id = $urandom;
    step(0, 0, 0, 1, '0, '0);
    step(1, 1, 0, 0, {$urandom, $urandom}, $urandom);
    idle_cycles(1);
    step(1, 1, 1, 1, '0, '0);
    n++;
    if ({FIFO_EMPTY, FIFO_DATA, FIFO_WORDS, LOST_DATA_CNT, BUSY} !== {1'b1, 32'd0, 10'd0, 8'd0, 1'b0}) begin
      nf++; $display("FAIL reset_mid: empty %b data %h words %0d lost %0d busy %b", FIFO_EMPTY, FIFO_DATA, FIFO_WORDS, LOST_DATA_CNT, BUSY);
    end
    step(1, 1, 0, 0, {$urandom, $urandom}, id);
    idle_cycles(3);
    n++;
    if (FIFO_WORDS !== 10'd3 || FIFO_DATA !== {2'b10, id[29:0]}) begin nf++; $display("FAIL reset_mid_rec: words %0d data %h exp 3 %h", FIFO_WORDS, FIFO_DATA, {2'b10, id[29:0]}); end
    drain("reset_mid");
  endtask
  task automatic test_fill;
    logic [63:0] ts;
    ts = {$urandom, $urandom};
    TIME_STAMP = ts; TRIG_ID = $urandom;
    s_rst = 1; @(posedge CLK40); @(negedge CLK40);
    s_rst = 0; s_trig = 1; @(posedge CLK40); @(negedge CLK40);
    s_trig = 0; repeat (3) @(posedge CLK40); @(negedge CLK40);
    s_trig = 1; @(posedge CLK40); @(negedge CLK40);
    s_trig = 0;
    n++;
    if (s_words !== 3'd3 || s_lost !== 8'd1 || s_busy !== 1'b0) begin nf++; $display("FAIL fill_drop: words %0d lost %0d busy %b exp 3 1 0", s_words, s_lost, s_busy); end
    s_read = 1; repeat (2) @(posedge CLK40); @(negedge CLK40);
    s_read = 0;
    n++;
    if (s_words !== 3'd1 || s_data !== {8'h00, ts[53:30]}) begin nf++; $display("FAIL fill_pop: words %0d data %h exp 1 %h", s_words, s_data, {8'h00, ts[53:30]}); end
    s_trig = 1; @(posedge CLK40); @(negedge CLK40);
    s_trig = 0; repeat (3) @(posedge CLK40); @(negedge CLK40);
    n++;
    if (s_words !== 3'd4 || s_lost !== 8'd1 || s_empty !== 1'b0) begin nf++; $display("FAIL fill_accept: words %0d lost %0d empty %b exp 4 1 0", s_words, s_lost, s_empty); end
  endtask
  task automatic test_random;
    int rp;
    step(0, 0, 0, 1, '0, '0);
    for (int c = 0; c < 3000; c++) begin
      rp = c < 1500 ? 5 : 70;
      step($urandom_range(0, 99) < 50, $urandom_range(0, 9) != 0, $urandom_range(0, 99) < rp,
           $urandom_range(0, 499) == 0, {$urandom, $urandom}, $urandom);
      n++;
      if (FIFO_EMPTY !== (exp_q.size() == 0) || FIFO_WORDS !== 10'(exp_q.size()) ||
          FIFO_DATA !== (exp_q.size() != 0 ? exp_q[0] : 32'd0) || LOST_DATA_CNT !== 8'(lost) || BUSY !== (pend.size() != 0)) begin
        nf++;
        $display("FAIL random cyc %0d: empty %b words %0d data %h lost %0d busy %b exp words %0d lost %0d busy %b",
                 c, FIFO_EMPTY, FIFO_WORDS, FIFO_DATA, LOST_DATA_CNT, BUSY, exp_q.size(), lost, pend.size() != 0);
      end
    end
  endtask
  initial begin
    repeat (2) @(negedge CLK40);
    test_reset;
    test_single;
    test_read_empty;
    test_back_to_back;
    test_concurrent;
    test_saturation;
    test_reset_mid;
    test_fill;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule

// File: doc/tlu_trigger_fifo.md
# tlu_trigger_fifo

Readout stage directly downstream of the TLU master core trigger logic. On every accepted trigger pulse it snapshots the 64-bit time stamp and 32-bit trigger ID. It serialises them into a three-word, 32-bit data record and buffers the words in an internal first-word-fall-through FIFO. This FIFO drives the core's `FIFO_READ` / `FIFO_EMPTY` / `FIFO_DATA` readout port. Triggers that cannot be stored are dropped and counted.

## Interface
- `DEPTH_LOG2`, default 9: FIFO depth is 2^DEPTH_LOG2 words; legal range is 2 to 14.

Ports:
- `CLK40` in 1: sole clock; every register and the FIFO are clocked on its rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `EN` in 1: trigger capture enable; when low, `TRIG` is ignored and not counted.
- `TRIG` in 1: single-cycle trigger pulse from the coincidence/handshake logic.
- `TIME_STAMP` in 64: free-running time stamp, sampled with `TRIG`.
- `TRIG_ID` in 32: trigger ID, sampled with `TRIG`.
- `FIFO_READ` in 1: pops the head word; ignored while `FIFO_EMPTY`.
- `FIFO_EMPTY` out 1: high when the FIFO holds no words.
- `FIFO_DATA` out 32: head word, valid while `FIFO_EMPTY` is low; 0 while empty.
- `FIFO_WORDS` out DEPTH_LOG2+1: current word count, 0 to 2^DEPTH_LOG2.
- `LOST_DATA_CNT` out 8: dropped-trigger counter, saturates at 8'hFF.
- `BUSY` out 1: high while the serializer is not IDLE.

## Operation
- FSM has four states: IDLE, WR0, WR1, WR2.
  - IDLE→WR0 on `TRIG & EN & accept`. WR0→WR1→WR2→IDLE unconditionally, one cycle each.
- `accept` = `(2^DEPTH_LOG2 − FIFO_WORDS) >= 3`, evaluated from the count before the current edge.
- On IDLE→WR0 the block registers `TIME_STAMP`, `TRIG_ID` and `min(LOST_DATA_CNT, 63)` as a snapshot.
- Words written, one per state:
  - WR0: {2'b10, TRIG_ID[29:0]}
  - WR1: {2'b01, TIME_STAMP[29:0]}
  - WR2: {2'b00, lost[5:0], TIME_STAMP[53:30]}
- Bits [31:30] = 2'b10 mark the record start.
- A record is always written complete. Space is guaranteed at acceptance, so a partial record never occurs.
- Drop rule: `TRIG & EN` while not IDLE, or while IDLE with `!accept`, increments `LOST_DATA_CNT`. The counter holds at 8'hFF.
- FIFO:
  - Circular RAM with wrapping read and write pointers plus an occupancy count.
  - Simultaneous write and pop leave `FIFO_WORDS` unchanged.
  - A pop while empty is ignored and does not change any pointer.
  - Full cannot be overrun because of the acceptance check.
- Reset, and the reset value of every output:
  - FSM goes to IDLE; pointers and count go to 0; `LOST_DATA_CNT` goes to 0.
  - `FIFO_EMPTY`=1, `FIFO_DATA`=0, `FIFO_WORDS`=0, `BUSY`=0.
  - `RST` mid-record aborts the record; already-written words are discarded because the pointers are cleared.
  - `RST` has priority over `TRIG` and `FIFO_READ` in the same cycle.

## Timing
- Let `TRIG` be sampled high at edge k.
  - The snapshot is taken at edge k.
  - Words are written at edges k+1, k+2 and k+3.
  - `FIFO_EMPTY` falls after edge k+1, given the FIFO was empty.
  - `BUSY` is high from after edge k through edge k+3.
- The earliest next accepted `TRIG` is sampled at edge k+4. `TRIG` at edges k+1 to k+3 is dropped.
- Read is FWFT:
  - `FIFO_DATA` shows the head word combinationally from the registered head, valid in the cycle `FIFO_EMPTY` is low.
  - A pop at edge j presents the next word after edge j.
  - Sustained reads at 1 word/cycle are supported.
- `FIFO_WORDS` updates at the same edge as the write or pop.
- `LOST_DATA_CNT` updates at the edge that samples the dropped `TRIG`.

## Test plan
- **Single trigger.** After reset, `TRIG` with TS=64'h0000_0000_4000_0005 and ID=32'h0000_0007.
  - Expect the words 32'h8000_0007, then 32'h4000_0005, then 32'h0000_0001.
  - `FIFO_EMPTY` falls after edge k+1; `FIFO_WORDS`=3 after k+3.
- **Back-to-back.** `TRIG` high for 6 consecutive cycles.
  - Expect 2 records accepted (edges k and k+4) and `LOST_DATA_CNT`=4.
  - The second record's W2 lost field = 3.
- **Fill.** DEPTH_LOG2=2 (4 words), no reads, two triggers.
  - Expect the first accepted and the second dropped; `FIFO_WORDS`=3 and `LOST_DATA_CNT`=1.
  - After 2 pops, a third trigger is accepted (free=3).
- **Read while empty and concurrent read/write.**
  - `FIFO_READ` while empty: no change to any output.
  - Pop in the same cycle as a WR1 write: `FIFO_WORDS` stays constant and data order is preserved.
- **Saturation and EN.**
  - 300 triggers dropped: `LOST_DATA_CNT`=8'hFF, and the embedded W2 lost field = 6'h3F.
  - With `EN`=0, `TRIG` changes nothing.
- **Reset mid-record.** `RST` in WR1.
  - All outputs return to their reset values; `FIFO_EMPTY`=1.
  - A following trigger produces a clean 3-word record.
